// File: rtl/wb_trace_buffer_if.sv
// Bundle between the MEM/WB stage and the write-back trace buffer: event inputs,
// display outputs and the FSM debug tap.
interface wb_trace_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          RegWrite;
  logic [4:0]    RegDest;
  logic [31:0]   WriteData;
  logic [31:0]   PC;
  logic          Freeze;
  logic          Clear;
  logic [12:0]   NumberA;
  logic [12:0]   NumberB;
  logic [4:0]    DispReg;
  logic          Valid;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          DbgState;

  // Handshake: an event is accepted on any rising edge with RegWrite=1 and no
  // backpressure; the display side is valid-only (Valid marks a shown entry).
  modport master (
    output RegWrite, RegDest, WriteData, PC, Freeze, Clear,
    input  NumberA, NumberB, DispReg, Valid, Count, Overflow, DbgState
  );

  modport slave (
    input  RegWrite, RegDest, WriteData, PC, Freeze, Clear,
    output NumberA, NumberB, DispReg, Valid, Count, Overflow, DbgState
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: queues register-file writes and shows each one for
// HOLD_CYCLES cycles. Optional macro WB_TRACE_ZERO_FILTER_EN drops $zero writes.
module wb_trace_buffer #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input logic           Clk,
  input logic           Rst,
  wb_trace_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t          state, nextState;
  logic [30:0]     mem [DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [CW-1:0]   count;
  logic [HW-1:0]   hold;
  logic [30:0]     dispEntry;
  logic            overflow;
  logic            pushReq, full, pop, decHold, doPush, ovfSet;
  logic [30:0]     newEntry;
  logic            unusedBits;

`ifdef WB_TRACE_ZERO_FILTER_EN
  assign pushReq = bus.RegWrite && (bus.RegDest != 5'd0);
`else
  assign pushReq = bus.RegWrite;
`endif

  assign newEntry   = {bus.RegDest, bus.PC[12:0], bus.WriteData[12:0]};
  assign full       = (count == CW'(DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign doPush     = pushReq && !bus.Clear && (!full || pop);
  assign ovfSet     = pushReq && !bus.Clear && full && !pop;
  assign unusedBits = ^{bus.WriteData[31:13], bus.PC[31:13]};

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    decHold   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          nextState = SHOW;
        end
      end
      SHOW: begin
        if (!bus.Freeze) begin
          if (hold != '0)        decHold   = 1'b1;
          else if (count != '0) pop       = 1'b1;
          else                  nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      hold      <= '0;
      dispEntry <= '0;
      overflow  <= 1'b0;
    end else if (bus.Clear) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      hold      <= '0;
      dispEntry <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= nextState;
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (pop) begin
        rdPtr     <= rdPtr + PW'(1);
        dispEntry <= mem[rdPtr];
        hold      <= HW'(HOLD_CYCLES - 1);
      end else if (decHold) begin
        hold <= hold - HW'(1);
      end
      count <= count + CW'(doPush) - CW'(pop);
      if (ovfSet) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone defines which slots are live.
  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= newEntry;
  end

  assign bus.NumberA  = dispEntry[12:0];
  assign bus.NumberB  = dispEntry[25:13];
  assign bus.DispReg  = dispEntry[30:26];
  assign bus.Valid    = (state == SHOW);
  assign bus.Count    = count;
  assign bus.Overflow = overflow;
  assign bus.DbgState = state;
endmodule
